// File: rtl/johnson_decoder.sv
// Johnson-code decoder with sequence tracking.
//
// Decodes a 4-bit Johnson counter code into a state index and its one-hot form.
// It also checks that successive codes advance in order. A tracker moves from
// SEARCH to LOCKED after LOCK_COUNT consecutive forward steps, and it counts
// violations and 7->0 wraps with counters that saturate.
//
// Ports:
//   Clock       system clock, rising-edge active
//   Reset       asynchronous, active-high reset
//   Code_in     4-bit Johnson code from the counter
//   Code_valid  Code_in is sampled on this Clock edge when high
//   Index_out   decoded state index 0..7 (holds on illegal codes)
//   Onehot_out  one-hot form of Index_out
//   Legal_out   last sampled code was one of the 8 legal codes
//   Lock_out    tracker is in LOCKED
//   Step_err    one-cycle pulse per violating sample
//   Wrap_count  completed 7->0 wraps while locked, saturating at 255
//   Err_count   total violations, saturating at 255
module johnson_decoder #(
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Code_in,
  input  logic       Code_valid,
  output logic [2:0] Index_out,
  output logic [7:0] Onehot_out,
  output logic       Legal_out,
  output logic       Lock_out,
  output logic       Step_err,
  output logic [7:0] Wrap_count,
  output logic [7:0] Err_count
);

  localparam logic [2:0] LockCount = 3'(LOCK_COUNT);

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  state_e     state_q, state_d;
  logic [2:0] run_q, run_d;
  logic       have_ref_q, have_ref_d;
  logic [2:0] index_q, index_d;
  logic [7:0] onehot_q, onehot_d;
  logic       legal_q, legal_d;
  logic       step_err_q, step_err_d;
  logic [7:0] wrap_q, wrap_d;
  logic [7:0] err_q, err_d;

  logic       code_legal;
  logic [2:0] code_index;
  logic [2:0] index_inc;
  logic [2:0] run_inc;
  logic       is_hold;
  logic       is_fwd;
  logic [7:0] err_sat_inc;
  logic [7:0] wrap_sat_inc;

  always_comb begin
    code_legal = 1'b1;
    code_index = 3'd0;
    case (Code_in)
      4'b0000: code_index = 3'd0;
      4'b0001: code_index = 3'd1;
      4'b0011: code_index = 3'd2;
      4'b0111: code_index = 3'd3;
      4'b1111: code_index = 3'd4;
      4'b1110: code_index = 3'd5;
      4'b1100: code_index = 3'd6;
      4'b1000: code_index = 3'd7;
      default: code_legal = 1'b0;
    endcase
  end

  assign index_inc    = index_q + 3'd1;
  assign run_inc      = run_q + 3'd1;
  assign is_hold      = (code_index == index_q);
  assign is_fwd       = (code_index == index_inc);
  assign err_sat_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  assign wrap_sat_inc = (wrap_q == 8'hFF) ? wrap_q : wrap_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    have_ref_d = have_ref_q;
    index_d    = index_q;
    onehot_d   = onehot_q;
    legal_d    = legal_q;
    step_err_d = 1'b0;
    wrap_d     = wrap_q;
    err_d      = err_q;

    if (Code_valid) begin
      legal_d = code_legal;
      if (!code_legal) begin
        // Illegal code is a violation in either state; index is kept.
        step_err_d = 1'b1;
        err_d      = err_sat_inc;
        run_d      = 3'd0;
        state_d    = StSearch;
      end else begin
        index_d    = code_index;
        onehot_d   = 8'b1 << code_index;
        have_ref_d = 1'b1;
        if (!have_ref_q) begin
          // First legal sample after reset only establishes the reference.
          run_d = 3'd0;
        end else if (state_q == StSearch) begin
          if (is_fwd) begin
            run_d = run_inc;
            if (run_inc == LockCount) state_d = StLocked;
          end else if (!is_hold) begin
            // Bad step while searching restarts the run silently.
            run_d = 3'd0;
          end
        end else begin
          if (is_fwd) begin
            if (index_q == 3'd7) wrap_d = wrap_sat_inc;
          end else if (!is_hold) begin
            step_err_d = 1'b1;
            err_d      = err_sat_inc;
            run_d      = 3'd0;
            state_d    = StSearch;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= StSearch;
      run_q      <= 3'd0;
      have_ref_q <= 1'b0;
      index_q    <= 3'd0;
      onehot_q   <= 8'h01;
      legal_q    <= 1'b0;
      step_err_q <= 1'b0;
      wrap_q     <= 8'd0;
      err_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      have_ref_q <= have_ref_d;
      index_q    <= index_d;
      onehot_q   <= onehot_d;
      legal_q    <= legal_d;
      step_err_q <= step_err_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign Index_out  = index_q;
  assign Onehot_out = onehot_q;
  assign Legal_out  = legal_q;
  assign Lock_out   = (state_q == StLocked);
  assign Step_err   = step_err_q;
  assign Wrap_count = wrap_q;
  assign Err_count  = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
module tb_johnson_decoder;

  logic       Clock;
  logic       Reset;
  logic [3:0] Code_in;
  logic       Code_valid;
  logic [2:0] Index_out;
  logic [7:0] Onehot_out;
  logic       Legal_out;
  logic       Lock_out;
  logic       Step_err;
  logic [7:0] Wrap_count;
  logic [7:0] Err_count;

  int n_vec;
  int n_bad;

  johnson_decoder #(.LOCK_COUNT(2)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Code_in    (Code_in),
    .Code_valid (Code_valid),
    .Index_out  (Index_out),
    .Onehot_out (Onehot_out),
    .Legal_out  (Legal_out),
    .Lock_out   (Lock_out),
    .Step_err   (Step_err),
    .Wrap_count (Wrap_count),
    .Err_count  (Err_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       v;
    logic [3:0] code;
    logic [2:0] idx;
    logic       legal;
    logic       lock;
    logic       serr;
    logic [7:0] wrap;
    logic [7:0] err;
  } vec_t;

  logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

  task automatic apply(input logic v, input logic [3:0] c);
    Code_valid = v;
    Code_in    = c;
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] idx, input logic legal,
                       input logic lock, input logic serr, input logic [7:0] wrap,
                       input logic [7:0] err);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    n_vec++;
    if (Index_out !== idx || Onehot_out !== oh || Legal_out !== legal ||
        Lock_out !== lock || Step_err !== serr || Wrap_count !== wrap ||
        Err_count !== err) begin
      n_bad++;
      $display("FAIL %s: got idx=%0d oh=%h legal=%b lock=%b serr=%b wrap=%0d err=%0d ; want idx=%0d oh=%h legal=%b lock=%b serr=%b wrap=%0d err=%0d",
               name, Index_out, Onehot_out, Legal_out, Lock_out, Step_err, Wrap_count,
               Err_count, idx, oh, legal, lock, serr, wrap, err);
    end
  endtask

  vec_t tbl [22];

  initial begin
    int exp_err;
    int exp_wrap;
    n_vec = 0;
    n_bad = 0;

    //          v  code     idx lg lk se wrap err
    tbl[0]  = '{1, 4'b0000, 0, 1, 0, 0, 0, 0};  // reference only
    tbl[1]  = '{1, 4'b0001, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 4'b0011, 2, 1, 1, 0, 0, 0};  // run hits 2 -> locked
    tbl[3]  = '{0, 4'b0101, 2, 1, 1, 0, 0, 0};  // invalid: hold
    tbl[4]  = '{1, 4'b0011, 2, 1, 1, 0, 0, 0};  // hold step
    tbl[5]  = '{1, 4'b0111, 3, 1, 1, 0, 0, 0};
    tbl[6]  = '{1, 4'b0101, 3, 0, 0, 1, 0, 1};  // illegal while locked
    tbl[7]  = '{1, 4'b0101, 3, 0, 0, 1, 0, 2};  // back-to-back illegal
    tbl[8]  = '{1, 4'b0111, 3, 1, 0, 0, 0, 2};  // hold relative to P=3
    tbl[9]  = '{1, 4'b1111, 4, 1, 0, 0, 0, 2};
    tbl[10] = '{1, 4'b1110, 5, 1, 1, 0, 0, 2};
    tbl[11] = '{1, 4'b1100, 6, 1, 1, 0, 0, 2};
    tbl[12] = '{1, 4'b1000, 7, 1, 1, 0, 0, 2};
    tbl[13] = '{1, 4'b0000, 0, 1, 1, 0, 1, 2};  // wrap while locked
    tbl[14] = '{1, 4'b0001, 1, 1, 1, 0, 1, 2};
    tbl[15] = '{1, 4'b0011, 2, 1, 1, 0, 1, 2};
    tbl[16] = '{1, 4'b0001, 1, 1, 0, 1, 1, 3};  // backward step while locked
    tbl[17] = '{1, 4'b0011, 2, 1, 0, 0, 1, 3};
    tbl[18] = '{1, 4'b0111, 3, 1, 1, 0, 1, 3};
    tbl[19] = '{1, 4'b1110, 5, 1, 0, 1, 1, 4};  // skip 3->5 while locked
    tbl[20] = '{1, 4'b0000, 0, 1, 0, 0, 1, 4};  // bad step in SEARCH: no error
    tbl[21] = '{0, 4'b0000, 0, 1, 0, 0, 1, 4};

    Reset      = 1'b1;
    Code_valid = 1'b0;
    Code_in    = 4'b0000;
    #1;
    check("reset_state", 0, 0, 0, 0, 0, 0);
    #11;
    Reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].v, tbl[i].code);
      check($sformatf("vec%0d", i), tbl[i].idx, tbl[i].legal, tbl[i].lock, tbl[i].serr,
            tbl[i].wrap, tbl[i].err);
    end

    // Saturation of Err_count with interleaved idle cycles.
    exp_err  = 4;
    exp_wrap = 1;
    for (int i = 0; i < 300; i++) begin
      apply(1'b1, 4'b1010);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      check("sat_illegal", 0, 0, 0, 1, 8'(exp_wrap), 8'(exp_err));
      if (i % 25 == 0) begin
        apply(1'b0, 4'b0001);
        check("sat_idle", 0, 0, 0, 0, 8'(exp_wrap), 8'(exp_err));
      end
    end

    // Async reset clears everything before any clock edge.
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset_1", 0, 0, 0, 0, 0, 0);
    #3;
    Reset = 1'b0;

    // Lock then complete five wraps.
    for (int i = 0; i <= 40; i++) begin
      apply(1'b1, codes[i % 8]);
      check($sformatf("wrap_seq%0d", i), 3'(i % 8), 1, (i >= 2), 0, 8'(i / 8), 0);
    end
    apply(1'b1, codes[1]);
    check("wrap5_locked", 1, 1, 1, 0, 5, 0);

    // Mid-cycle reset while locked with Wrap_count=5.
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset_2", 0, 0, 0, 0, 0, 0);
    apply(1'b1, 4'b0001);
    check("edge_in_reset", 0, 0, 0, 0, 0, 0);
    #2;
    Reset = 1'b0;

    // First legal sample after reset is a reference only.
    apply(1'b1, 4'b0011);
    check("post_rst_ref", 2, 1, 0, 0, 0, 0);
    apply(1'b1, 4'b0001);
    check("post_rst_bad", 1, 1, 0, 0, 0, 0);
    apply(1'b1, 4'b0011);
    check("post_rst_fwd1", 2, 1, 0, 0, 0, 0);
    apply(1'b1, 4'b0111);
    check("post_rst_lock", 3, 1, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
